// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler that shares one small ALU between two requesters.
// Add/sub finish after one execute cycle; multiplies use a one-bit-per-cycle shift-add engine.
module alu_share_sched #(
  parameter int NBITS_OP  = 3,
  parameter int NBITS_RES = 8
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [3:0]            req_op,
  input  logic [2*NBITS_OP-1:0] req_a,
  input  logic [2*NBITS_OP-1:0] req_b,
  output logic [1:0]            req_ready,
  output logic                  res_valid,
  output logic                  res_id,
  output logic [NBITS_RES-1:0]  res_data,
  output logic                  busy
);

  localparam int CW   = (NBITS_OP > 1) ? $clog2(NBITS_OP) : 1;
  localparam int PADW = NBITS_RES - NBITS_OP - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One extra bit so that the most negative operand still has a representable magnitude.
  function automatic logic [NBITS_OP:0] magnitude(input logic [NBITS_OP-1:0] v, input logic is_signed);
    logic [NBITS_OP:0] ext;
    ext = {is_signed & v[NBITS_OP-1], v};
    if (ext[NBITS_OP]) begin
      magnitude = -ext;
    end else begin
      magnitude = ext;
    end
  endfunction

  function automatic logic [NBITS_RES-1:0] zext(input logic [NBITS_OP-1:0] v);
    zext = {{(NBITS_RES-NBITS_OP){1'b0}}, v};
  endfunction

  state_t                state_r;
  logic                  ptr_r;
  logic                  id_r;
  logic                  mode_r;   // op bit 0: subtract for add/sub, signed for multiply
  logic [NBITS_OP-1:0]   a_r;
  logic [NBITS_OP-1:0]   b_r;
  logic [CW-1:0]         cnt_r;
  logic [NBITS_RES-1:0]  acc_r;
  logic                  res_valid_r;
  logic                  res_id_r;
  logic [NBITS_RES-1:0]  res_data_r;
  logic                  busy_r;

  logic                  grant_s;
  logic                  accept_s;
  logic [1:0]            sel_op_s;
  logic [NBITS_OP-1:0]   sel_a_s;
  logic [NBITS_OP-1:0]   sel_b_s;
  logic [NBITS_OP:0]     mag_a_s;
  logic [NBITS_OP:0]     mag_b_s;
  logic                  neg_s;
  logic [NBITS_RES-1:0]  partial_s;
  logic [NBITS_RES-1:0]  acc_next_s;
  logic [NBITS_RES-1:0]  prod_s;
  logic [NBITS_RES-1:0]  addsub_s;

  // Round-robin arbitration and same-cycle accept strobe.
  always_comb begin
    case (req_valid)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ptr_r;
      default: grant_s = 1'b0;
    endcase
    accept_s = rst_n && (state_r == IDLE) && (req_valid != 2'b00);
    if (accept_s) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    if (grant_s) begin
      sel_op_s = req_op[3:2];
      sel_a_s  = req_a[2*NBITS_OP-1:NBITS_OP];
      sel_b_s  = req_b[2*NBITS_OP-1:NBITS_OP];
    end else begin
      sel_op_s = req_op[1:0];
      sel_a_s  = req_a[NBITS_OP-1:0];
      sel_b_s  = req_b[NBITS_OP-1:0];
    end
  end

  // ALU datapath: add/sub result and one shift-add step on operand magnitudes.
  always_comb begin
    mag_a_s   = magnitude(a_r, mode_r);
    mag_b_s   = magnitude(b_r, mode_r);
    neg_s     = mode_r & (a_r[NBITS_OP-1] ^ b_r[NBITS_OP-1]);
    partial_s = {{PADW{1'b0}}, mag_a_s} << cnt_r;
    if (mag_b_s[cnt_r]) begin
      acc_next_s = acc_r + partial_s;
    end else begin
      acc_next_s = acc_r;
    end
    if (neg_s) begin
      prod_s = -acc_next_s;
    end else begin
      prod_s = acc_next_s;
    end
    if (mode_r) begin
      addsub_s = zext(a_r) - zext(b_r);
    end else begin
      addsub_s = zext(a_r) + zext(b_r);
    end
  end

  // Scheduler FSM with registered result outputs.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      id_r        <= 1'b0;
      mode_r      <= 1'b0;
      a_r         <= {NBITS_OP{1'b0}};
      b_r         <= {NBITS_OP{1'b0}};
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {NBITS_RES{1'b0}};
      res_valid_r <= 1'b0;
      res_id_r    <= 1'b0;
      res_data_r  <= {NBITS_RES{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          res_valid_r <= 1'b0;
          if (accept_s) begin
            ptr_r   <= ~grant_s;
            id_r    <= grant_s;
            mode_r  <= sel_op_s[0];
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {NBITS_RES{1'b0}};
            busy_r  <= 1'b1;
            state_r <= sel_op_s[1] ? MUL : EXEC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_data_r  <= addsub_s;
          res_id_r    <= id_r;
          res_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        MUL: begin
          acc_r <= acc_next_s;
          if (cnt_r == CW'(NBITS_OP-1)) begin
            res_data_r  <= prod_s;
            res_id_r    <= id_r;
            res_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= MUL;
          end
        end
        DONE: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_data  = res_data_r;
  assign busy      = busy_r;

endmodule
